// File: rtl/hdmi_pkg.sv
// Shared TMDS constants, lane indices and the 2-bit chunk selector used by the
// shift scheduler and its lane shifters.
package hdmi_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t  TMDS_BLANK_SYM   = 10'b1101010100;
  localparam tmds_sym_t  TMDS_CLK_PATTERN = 10'b1111100000;
  localparam logic [2:0] PHASE_LAST       = 3'd4;

  localparam int LANE_R   = 0;
  localparam int LANE_G   = 1;
  localparam int LANE_B   = 2;
  localparam int LANE_CLK = 3;

  // Chunk for phase p is sym[2p+1:2p]; phase never exceeds PHASE_LAST.
  function automatic logic [1:0] sym_chunk(input tmds_sym_t sym, input logic [2:0] ph);
    case (ph)
      3'd0:    sym_chunk = sym[1:0];
      3'd1:    sym_chunk = sym[3:2];
      3'd2:    sym_chunk = sym[5:4];
      3'd3:    sym_chunk = sym[7:6];
      default: sym_chunk = sym[9:8];
    endcase
  endfunction

endpackage

// File: rtl/tmds_lane_shift.sv
// One TMDS data lane: 10-bit symbol register loaded at the symbol boundary,
// presenting the 2-bit chunk selected by the current phase.
module tmds_lane_shift
  import hdmi_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  tmds_sym_t  i_sym,
  input  logic [2:0] i_phase,
  output logic [1:0] o_chunk
);

  tmds_sym_t r_shift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= TMDS_BLANK_SYM;
    end else if (i_load) begin
      r_shift <= i_sym;
    end
  end

  assign o_chunk = sym_chunk(r_shift, i_phase);

endmodule

// File: rtl/hdmi_tmds_shift_scheduler.sv
// HDMI TMDS shift scheduler: 1-entry hold buffer feeding three 10-bit lane shifters
// plus the clock lane, 2 bits/lane/cycle. Define HDMI_SHIFTER_UFCNT_EN for underflow_count.
module hdmi_tmds_shift_scheduler
  import hdmi_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  tmds_sym_t  sym_r,
  input  tmds_sym_t  sym_g,
  input  tmds_sym_t  sym_b,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] pos,
  output logic [7:0] neg,
  output logic       underflow,
  output logic [2:0] phase
`ifdef HDMI_SHIFTER_UFCNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  logic [2:0] r_phase;
  tmds_sym_t  r_hold [3];
  logic       r_hold_valid;
  logic [7:0] r_pos;
  logic [7:0] r_neg;

  logic       w_last;
  logic       w_take;
  logic       w_hold_use;
  tmds_sym_t  w_sym_in [3];
  logic [1:0] w_chunk [3];
  logic [7:0] w_pos_nxt;

  assign w_last     = (r_phase == PHASE_LAST);
  // Gating with reset_n keeps ready low while the block is held in reset.
  assign sym_ready  = reset_n & enable & (~r_hold_valid | w_last);
  assign w_take     = sym_valid & sym_ready;
  assign w_hold_use = r_hold_valid & enable;
  assign underflow  = w_last & ~r_hold_valid & enable;

  assign w_sym_in[LANE_R] = sym_r;
  assign w_sym_in[LANE_G] = sym_g;
  assign w_sym_in[LANE_B] = sym_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 3'd0;
    end else begin
      r_phase <= w_last ? 3'd0 : r_phase + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      for (int i = 0; i < 3; i++) r_hold[i] <= TMDS_BLANK_SYM;
    end else if (w_take) begin
      r_hold_valid <= 1'b1;
      for (int i = 0; i < 3; i++) r_hold[i] <= w_sym_in[i];
    end else if (!enable || w_last) begin
      r_hold_valid <= 1'b0;
    end
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_lane
    tmds_lane_shift u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_last),
      .i_sym   (w_hold_use ? r_hold[gi] : TMDS_BLANK_SYM),
      .i_phase (r_phase),
      .o_chunk (w_chunk[gi])
    );
  end

  always_comb begin
    w_pos_nxt = 8'h00;
    for (int i = 0; i < 3; i++) w_pos_nxt[2*i +: 2] = w_chunk[i];
    w_pos_nxt[2*LANE_CLK +: 2] = sym_chunk(TMDS_CLK_PATTERN, r_phase);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pos <= 8'h00;
      r_neg <= 8'hFF;
    end else begin
      r_pos <= w_pos_nxt;
      r_neg <= ~w_pos_nxt;
    end
  end

  assign pos   = r_pos;
  assign neg   = r_neg;
  assign phase = r_phase;

`ifdef HDMI_SHIFTER_UFCNT_EN
  logic [15:0] r_uf_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uf_count <= 16'h0000;
    end else if (underflow && (r_uf_count != 16'hFFFF)) begin
      r_uf_count <= r_uf_count + 16'd1;
    end
  end

  assign underflow_count = r_uf_count;
`endif

endmodule

// File: tb/tb_hdmi_tmds_shift_scheduler.sv
// Self-checking bench: symbol-stream reference model (FIFO of accepted triplets,
// current symbol, phase count) compared every cycle, plus scenario checks.
module tb_hdmi_tmds_shift_scheduler;

  localparam logic [9:0] BLANK   = 10'b1101010100;
  localparam logic [9:0] CLK_PAT = 10'b1111100000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [9:0]  sym_r = '0, sym_g = '0, sym_b = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [7:0]  pos, neg;
  logic        underflow;
  logic [2:0]  phase;
`ifdef HDMI_SHIFTER_UFCNT_EN
  logic [15:0] underflow_count;
`endif

  hdmi_tmds_shift_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .sym_r     (sym_r),
    .sym_g     (sym_g),
    .sym_b     (sym_b),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .pos       (pos),
    .neg       (neg),
    .underflow (underflow),
    .phase     (phase)
`ifdef HDMI_SHIFTER_UFCNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: symbol-level view of the transmitter.
  int          m_ph;
  logic [29:0] m_pend[$];
  logic [29:0] m_cur;
  int          uf_seen;
  logic        last_take, last_rdy, last_uf;
  int          last_ph;
  logic [1:0]  clk_tab [5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};

  function automatic logic [1:0] chunk(input logic [9:0] s, input int k);
    logic [9:0] t;
    t = s >> (2 * k);
    return t[1:0];
  endfunction

  function automatic logic [29:0] rand_trip();
    return {10'($urandom), 10'($urandom), 10'($urandom)};
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_pend.delete();
    m_cur = {3{BLANK}};
    uf_seen = 0;
  endtask

  // One clock cycle: drive, compare pre-edge outputs, advance model, compare registered outputs.
  task automatic cyc(input logic en, input logic vld, input logic [29:0] trip);
    logic       exp_rdy, exp_uf;
    logic [7:0] exp_pos;
    enable = en;
    sym_valid = vld;
    {sym_b, sym_g, sym_r} = trip;
    #1;
    exp_rdy = en && (m_pend.size() == 0 || m_ph == 4);
    exp_uf  = en && (m_ph == 4) && (m_pend.size() == 0);
    checks += 3;
    if (sym_ready !== exp_rdy) begin
      errors++; $display("FAIL ready t=%0t got %b exp %b", $time, sym_ready, exp_rdy);
    end
    if (underflow !== exp_uf) begin
      errors++; $display("FAIL underflow t=%0t got %b exp %b", $time, underflow, exp_uf);
    end
    if (phase !== 3'(m_ph)) begin
      errors++; $display("FAIL phase t=%0t got %0d exp %0d", $time, phase, m_ph);
    end
    last_rdy  = sym_ready;
    last_uf   = underflow;
    last_ph   = m_ph;
    last_take = vld && exp_rdy;
    if (exp_uf) uf_seen++;
    exp_pos = {chunk(CLK_PAT, m_ph), chunk(m_cur[29:20], m_ph),
               chunk(m_cur[19:10], m_ph), chunk(m_cur[9:0], m_ph)};
    if (m_ph == 4) begin
      if (en && m_pend.size() > 0) m_cur = m_pend.pop_front();
      else m_cur = {3{BLANK}};
    end
    if (!en) m_pend.delete();
    if (last_take) m_pend.push_back(trip);
    m_ph = (m_ph + 1) % 5;
    @(posedge clock);
    #1;
    checks += 2;
    if (pos !== exp_pos) begin
      errors++; $display("FAIL pos t=%0t got %h exp %h", $time, pos, exp_pos);
    end
    if (neg !== ~exp_pos) begin
      errors++; $display("FAIL neg t=%0t got %h exp %h", $time, neg, ~exp_pos);
    end
`ifdef HDMI_SHIFTER_UFCNT_EN
    checks++;
    if (underflow_count !== 16'((uf_seen > 65535) ? 65535 : uf_seen)) begin
      errors++; $display("FAIL uf_count t=%0t got %0d exp %0d", $time, underflow_count, uf_seen);
    end
`endif
  endtask

  task automatic idle_until_phase(input int ph);
    int n = 0;
    while (m_ph != ph && n < 10) begin
      cyc(1'b1, 1'b0, rand_trip());
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks += 5;
    if (pos !== 8'h00)     begin errors++; $display("FAIL rst_pos got %h exp 00", pos); end
    if (neg !== 8'hFF)     begin errors++; $display("FAIL rst_neg got %h exp ff", neg); end
    if (sym_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", sym_ready); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL rst_uf got %b exp 0", underflow); end
    if (phase !== 3'd0)    begin errors++; $display("FAIL rst_phase got %0d exp 0", phase); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_blank();
    int uf0 = uf_seen;
    repeat (10) cyc(1'b1, 1'b0, rand_trip());
    checks++;
    if (uf_seen - uf0 != 2) begin
      errors++; $display("FAIL idle_uf_pulses got %0d exp 2", uf_seen - uf0);
    end
  endtask

  task automatic test_single_triplet();
    logic [29:0] trip = {10'h155, 10'h000, 10'h3FF};
    idle_until_phase(1);
    cyc(1'b1, 1'b1, trip);
    checks++;
    if (last_take !== 1'b1) begin errors++; $display("FAIL single_take got %b exp 1", last_take); end
    idle_until_phase(0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, rand_trip());
      checks++;
      if (pos[5:0] !== 6'b01_00_11) begin
        errors++; $display("FAIL single_chunk%0d got %b exp 010011", k, pos[5:0]);
      end
    end
  endtask

  task automatic test_clock_lane();
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 9) != 0, 1'($urandom), rand_trip());
      checks++;
      if (pos[7:6] !== clk_tab[last_ph]) begin
        errors++; $display("FAIL clk_lane ph=%0d got %b exp %b", last_ph, pos[7:6], clk_tab[last_ph]);
      end
    end
    repeat (10) cyc(1'b1, 1'b0, rand_trip());
  endtask

  task automatic test_back_to_back();
    logic [29:0] trips [4];
    int idx = 0, n = 0, uf_after = 0, early_rdy = 0;
    for (int i = 0; i < 4; i++) trips[i] = rand_trip();
    while (idx < 4 && n < 40) begin
      cyc(1'b1, 1'b1, trips[idx]);
      n++;
      if (idx > 0 && last_uf) uf_after++;
      if (idx > 0 && last_ph != 4 && last_rdy) early_rdy++;
      if (last_take) begin
        if (idx > 0) begin
          checks++;
          if (last_ph != 4) begin
            errors++; $display("FAIL stream_take_phase idx=%0d got %0d exp 4", idx, last_ph);
          end
        end
        idx++;
      end
    end
    checks += 3;
    if (idx != 4) begin errors++; $display("FAIL stream_count got %0d exp 4", idx); end
    if (uf_after != 0) begin errors++; $display("FAIL stream_uf got %0d exp 0", uf_after); end
    if (early_rdy != 0) begin errors++; $display("FAIL stream_ready_early got %0d exp 0", early_rdy); end
    repeat (12) cyc(1'b1, 1'b0, rand_trip());
  endtask

  task automatic test_disable();
    logic [29:0] a = rand_trip();
    logic [29:0] b = {10'h2A3, 10'h0F1, 10'h3C7};
    int uf0, n = 0;
    repeat (5) cyc(1'b1, 1'b0, rand_trip());
    idle_until_phase(1);
    cyc(1'b1, 1'b1, a);
    idle_until_phase(4);
    cyc(1'b1, 1'b1, b);
    checks++;
    if (last_take !== 1'b1) begin errors++; $display("FAIL dis_take_b got %b exp 1", last_take); end
    cyc(1'b1, 1'b0, rand_trip());
    uf0 = uf_seen;
    while (m_ph != 0 && n < 10) begin
      cyc(1'b0, 1'b1, rand_trip());
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, rand_trip());
      checks++;
      if (pos[5:0] !== {3{chunk(BLANK, k)}}) begin
        errors++; $display("FAIL dis_blank%0d got %b exp %b", k, pos[5:0], {3{chunk(BLANK, k)}});
      end
    end
    checks++;
    if (uf_seen != uf0) begin errors++; $display("FAIL dis_uf got %0d exp 0", uf_seen - uf0); end
    repeat (5) cyc(1'b1, 1'b0, rand_trip());
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, rand_trip());
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (pos !== 8'h00)  begin errors++; $display("FAIL arst_pos got %h exp 00", pos); end
    if (neg !== 8'hFF)  begin errors++; $display("FAIL arst_neg got %h exp ff", neg); end
    if (phase !== 3'd0) begin errors++; $display("FAIL arst_phase got %0d exp 0", phase); end
`ifdef HDMI_SHIFTER_UFCNT_EN
    checks++;
    if (underflow_count !== 16'd0) begin
      errors++; $display("FAIL arst_uf_count got %0d exp 0", underflow_count);
    end
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (12) cyc(1'b1, 1'b0, rand_trip());
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, rand_trip());
    end
  endtask

  initial begin
    model_reset();
    last_take = 1'b0; last_rdy = 1'b0; last_uf = 1'b0; last_ph = 0;
    test_reset();
    test_idle_blank();
    test_single_triplet();
    test_clock_lane();
    test_back_to_back();
    test_disable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
